mul_add: RTL

Sequential shift-and-add multiply-accumulate computing `product = a * b + c`. It is the inverse of the quotient/divisor/remainder path: `quotient * divisor + remainder` reconstructs the dividend. Used to check divider results in-system and to rescale quotients back into the dividend domain. It sits behind a valid/ready handshake and uses one adder with fixed latency.

---
 rtl/mul_add.sv | 119 +++++++++++
 1 files changed

// File: rtl/mul_add.sv
// mul_add: sequential shift-and-add multiply-accumulate, product = a*b + c.
// One adder, fixed latency of M cycles per operation, valid/ready on both sides.
// Typical use is rebuilding a dividend from quotient/divisor/remainder.
module mul_add #(
   parameter int M = 26,
   parameter int N = 14
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [M-1:0]     a,
   input  logic [N-1:0]     b,
   input  logic [N-1:0]     c,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [M+N-1:0]   product,
   output logic             ovf
);

   localparam int CW = (M > 1) ? $clog2(M) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(M - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [M+N-1:0]      r_acc;
   logic [M+N-1:0]      r_mcand;
   logic [M-1:0]        r_mplier;
   logic [CW-1:0]       r_cnt;
   logic                w_load;
   logic                w_step;

   // Next-state logic: capture in IDLE, exactly M steps in RUN, wait for consumer in DONE.
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_step      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (in_valid) begin
               w_load      = 1'b1;
               w_state_nxt = S_RUN;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_RUN: begin
            w_step = 1'b1;
            if (r_cnt == CNT_LAST) begin
               w_state_nxt = S_DONE;
            end else begin
               w_state_nxt = S_RUN;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_state_nxt = S_DONE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State register; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Datapath: load operands on capture, one conditional add and shift per RUN cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_cnt    <= '0;
      end else if (w_load) begin
         r_acc    <= {{M{1'b0}}, c};
         r_mcand  <= {{M{1'b0}}, b};
         r_mplier <= a;
         r_cnt    <= '0;
      end else if (w_step) begin
         // The sum cannot exceed 2^N*(2^M-1), so M+N bits never wrap.
         if (r_mplier[0]) begin
            r_acc <= r_acc + r_mcand;
         end else begin
            r_acc <= r_acc;
         end
         r_mplier <= r_mplier >> 1;
         r_mcand  <= r_mcand << 1;
         r_cnt    <= r_cnt + CW'(1);
      end else begin
         r_acc    <= r_acc;
         r_mcand  <= r_mcand;
         r_mplier <= r_mplier;
         r_cnt    <= r_cnt;
      end
   end

   // Handshake flags and result are decoded from registers only.
   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = (r_state == S_DONE);
   assign product   = r_acc;
   assign ovf       = |r_acc[M+N-1:M];

endmodule
